// File: rtl/alu_iq_pkg.sv
// Shared core types for the ALU issue queue: PRF/ROB geometry, ALU op encoding,
// queue entry layout and PR bank helpers.
package alu_iq_pkg;
    localparam int PRF_BANK_COUNT     = 4;
    localparam int LOG_PRF_BANK_COUNT = 2;
    localparam int LOG_PR_COUNT       = 7;
    localparam int LOG_ROB_ENTRIES    = 7;
    localparam int UPPER_PR_W         = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

    typedef logic [LOG_PR_COUNT-1:0]       pr_t;
    typedef logic [LOG_PRF_BANK_COUNT-1:0] bank_t;
    typedef logic [UPPER_PR_W-1:0]         upper_pr_t;
    typedef logic [LOG_ROB_ENTRIES-1:0]    rob_idx_t;
    typedef logic [PRF_BANK_COUNT-1:0][UPPER_PR_W-1:0] wb_upper_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_t;

    typedef struct packed {
        logic        valid;
        alu_op_t     op;
        logic        is_imm;
        logic [31:0] imm;
        logic        A_unneeded;
        pr_t         A_PR;
        logic        A_ready;
        pr_t         B_PR;
        logic        B_ready;
        pr_t         dest_PR;
        rob_idx_t    ROB_index;
    } alu_iq_entry_t;

    function automatic bank_t pr_bank(pr_t pr);
        return pr[LOG_PRF_BANK_COUNT-1:0];
    endfunction

    function automatic upper_pr_t pr_upper(pr_t pr);
        return pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
    endfunction
endpackage

// File: rtl/alu_iq_if.sv
// Dispatch, writeback-bus, issue and PRF-read signals around the ALU issue queue.
interface alu_iq_if;
    import alu_iq_pkg::*;

    logic                      dispatch_valid;
    logic [3:0]                dispatch_op;
    logic                      dispatch_is_imm;
    logic [31:0]               dispatch_imm;
    logic                      dispatch_A_unneeded;
    pr_t                       dispatch_A_PR;
    logic                      dispatch_A_ready;
    pr_t                       dispatch_B_PR;
    logic                      dispatch_B_ready;
    pr_t                       dispatch_dest_PR;
    rob_idx_t                  dispatch_ROB_index;
    logic                      dispatch_ready;

    logic [PRF_BANK_COUNT-1:0] WB_bus_valid_by_bank;
    wb_upper_t                 WB_bus_upper_PR_by_bank;

    logic                      issue_valid;
    logic [3:0]                issue_op;
    logic                      issue_is_imm;
    logic [31:0]               issue_imm;
    logic                      issue_A_unneeded;
    logic                      issue_A_forward;
    bank_t                     issue_A_bank;
    logic                      issue_B_forward;
    bank_t                     issue_B_bank;
    pr_t                       issue_dest_PR;
    rob_idx_t                  issue_ROB_index;
    logic                      issue_ready;

    logic                      PRF_req_A_valid;
    pr_t                       PRF_req_A_PR;
    logic                      PRF_req_B_valid;
    pr_t                       PRF_req_B_PR;

    modport master (
        output dispatch_valid, dispatch_op, dispatch_is_imm, dispatch_imm, dispatch_A_unneeded,
               dispatch_A_PR, dispatch_A_ready, dispatch_B_PR, dispatch_B_ready,
               dispatch_dest_PR, dispatch_ROB_index,
               WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank, issue_ready,
        input  dispatch_ready, issue_valid, issue_op, issue_is_imm, issue_imm, issue_A_unneeded,
               issue_A_forward, issue_A_bank, issue_B_forward, issue_B_bank, issue_dest_PR,
               issue_ROB_index, PRF_req_A_valid, PRF_req_A_PR, PRF_req_B_valid, PRF_req_B_PR
    );

    modport slave (
        input  dispatch_valid, dispatch_op, dispatch_is_imm, dispatch_imm, dispatch_A_unneeded,
               dispatch_A_PR, dispatch_A_ready, dispatch_B_PR, dispatch_B_ready,
               dispatch_dest_PR, dispatch_ROB_index,
               WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank, issue_ready,
        output dispatch_ready, issue_valid, issue_op, issue_is_imm, issue_imm, issue_A_unneeded,
               issue_A_forward, issue_A_bank, issue_B_forward, issue_B_bank, issue_dest_PR,
               issue_ROB_index, PRF_req_A_valid, PRF_req_A_PR, PRF_req_B_valid, PRF_req_B_PR
    );
endinterface

// File: rtl/alu_iq_pe_lsb.sv
// Lowest-set-bit priority encoder: one-hot of the lowest request, its index, and any-set.
module alu_iq_pe_lsb #(
    parameter int WIDTH = 8,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    assign onehot = req & (~req + WIDTH'(1));
    assign any    = |req;

    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end
endmodule

// File: rtl/alu_iq.sv
// Compressing oldest-first ALU issue queue: wakeup from the PRF writeback bus,
// one issue per cycle with PRF read requests or writeback forwarding per operand.
module alu_iq
    import alu_iq_pkg::*;
#(
    parameter int ALU_IQ_ENTRIES = 8
) (
    input logic     CLK,
    input logic     RST,
    alu_iq_if.slave bus
);
    localparam int IDX_W = $clog2(ALU_IQ_ENTRIES);
    localparam int CNT_W = $clog2(ALU_IQ_ENTRIES + 1);

    alu_iq_entry_t             q       [ALU_IQ_ENTRIES];
    alu_iq_entry_t             q_n     [ALU_IQ_ENTRIES];
    alu_iq_entry_t             woken   [ALU_IQ_ENTRIES+1];
    alu_iq_entry_t             new_entry;
    alu_iq_entry_t             sel;
    logic [CNT_W-1:0]          count;
    logic [CNT_W-1:0]          wr_idx;
    logic [ALU_IQ_ENTRIES-1:0] a_wb, b_wb, elig, sel_oh;
    logic [IDX_W-1:0]          sel_idx;
    logic                      sel_any, do_issue, accept;
    logic                      a_fwd, b_fwd, a_req, b_req;

    function automatic logic wb_match(pr_t pr, logic [PRF_BANK_COUNT-1:0] vld, wb_upper_t upper);
        return vld[pr_bank(pr)] && (upper[pr_bank(pr)] == pr_upper(pr));
    endfunction

    // Wakeup and eligibility; woken[] carries this cycle's ready bits into the next state.
    always_comb begin
        for (int i = 0; i < ALU_IQ_ENTRIES; i++) begin
            a_wb[i] = wb_match(q[i].A_PR, bus.WB_bus_valid_by_bank, bus.WB_bus_upper_PR_by_bank);
            b_wb[i] = wb_match(q[i].B_PR, bus.WB_bus_valid_by_bank, bus.WB_bus_upper_PR_by_bank);
            elig[i] = q[i].valid
                   && (q[i].A_unneeded || q[i].A_ready || a_wb[i])
                   && (q[i].is_imm     || q[i].B_ready || b_wb[i]);
            woken[i]         = q[i];
            woken[i].A_ready = q[i].A_ready || (q[i].valid && a_wb[i]);
            woken[i].B_ready = q[i].B_ready || (q[i].valid && b_wb[i]);
        end
        woken[ALU_IQ_ENTRIES] = '0;
    end

    alu_iq_pe_lsb #(.WIDTH(ALU_IQ_ENTRIES)) u_pe (
        .req    (elig),
        .onehot (sel_oh),
        .idx    (sel_idx),
        .any    (sel_any)
    );

    // AND-OR mux keeps every issue field at zero when nothing is selected.
    always_comb begin
        sel = '0;
        for (int i = 0; i < ALU_IQ_ENTRIES; i++) begin
            if (sel_oh[i]) sel = alu_iq_entry_t'(sel | q[i]);
        end
    end

    assign do_issue = sel_any && bus.issue_ready;
    assign accept   = bus.dispatch_valid && bus.dispatch_ready;
    assign wr_idx   = count - CNT_W'(do_issue);

    always_comb begin
        a_fwd = sel_any && !sel.A_unneeded && !sel.A_ready;
        b_fwd = sel_any && !sel.is_imm && !sel.B_ready;
        a_req = do_issue && !sel.A_unneeded && sel.A_ready;
        b_req = do_issue && !sel.is_imm && sel.B_ready;
    end

    assign bus.dispatch_ready   = (count < CNT_W'(ALU_IQ_ENTRIES));
    assign bus.issue_valid      = sel_any;
    assign bus.issue_op         = sel.op;
    assign bus.issue_is_imm     = sel.is_imm;
    assign bus.issue_imm        = sel.imm;
    assign bus.issue_A_unneeded = sel.A_unneeded;
    assign bus.issue_A_forward  = a_fwd;
    assign bus.issue_A_bank     = a_fwd ? pr_bank(sel.A_PR) : '0;
    assign bus.issue_B_forward  = b_fwd;
    assign bus.issue_B_bank     = b_fwd ? pr_bank(sel.B_PR) : '0;
    assign bus.issue_dest_PR    = sel.dest_PR;
    assign bus.issue_ROB_index  = sel.ROB_index;
    assign bus.PRF_req_A_valid  = a_req;
    assign bus.PRF_req_A_PR     = a_req ? sel.A_PR : '0;
    assign bus.PRF_req_B_valid  = b_req;
    assign bus.PRF_req_B_PR     = b_req ? sel.B_PR : '0;

    // Compaction: everything at or above the issued slot shifts down; dispatch lands at the new tail.
    always_comb begin
        new_entry            = '0;
        new_entry.valid      = 1'b1;
        new_entry.op         = alu_op_t'(bus.dispatch_op);
        new_entry.is_imm     = bus.dispatch_is_imm;
        new_entry.imm        = bus.dispatch_imm;
        new_entry.A_unneeded = bus.dispatch_A_unneeded;
        new_entry.A_PR       = bus.dispatch_A_PR;
        new_entry.A_ready    = bus.dispatch_A_ready
            || wb_match(bus.dispatch_A_PR, bus.WB_bus_valid_by_bank, bus.WB_bus_upper_PR_by_bank);
        new_entry.B_PR       = bus.dispatch_B_PR;
        new_entry.B_ready    = bus.dispatch_B_ready
            || wb_match(bus.dispatch_B_PR, bus.WB_bus_valid_by_bank, bus.WB_bus_upper_PR_by_bank);
        new_entry.dest_PR    = bus.dispatch_dest_PR;
        new_entry.ROB_index  = bus.dispatch_ROB_index;

        for (int i = 0; i < ALU_IQ_ENTRIES; i++) begin
            q_n[i] = (do_issue && IDX_W'(i) >= sel_idx) ? woken[i+1] : woken[i];
        end
        if (accept) q_n[wr_idx[IDX_W-1:0]] = new_entry;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
            for (int i = 0; i < ALU_IQ_ENTRIES; i++) q[i] <= '0;
        end else begin
            count <= count + CNT_W'(accept) - CNT_W'(do_issue);
            q     <= q_n;
        end
    end
endmodule

// File: tb/tb_alu_iq.sv
// Scoreboard bench for alu_iq: expected issues are queued at dispatch time and
// compared field-by-field whenever the queue issues into a ready pipeline.
module tb_alu_iq;
    import alu_iq_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    alu_iq_if bus();

    alu_iq #(.ALU_IQ_ENTRIES(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [95:0] exp_q[$];
    logic [95:0] w;

    task automatic check_val(string tag, logic [95:0] obs, logic [95:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] iss_word();
        return {22'b0, bus.issue_op, bus.issue_is_imm, bus.issue_imm, bus.issue_A_unneeded,
                bus.issue_A_forward, bus.issue_A_bank, bus.issue_B_forward, bus.issue_B_bank,
                bus.issue_dest_PR, bus.issue_ROB_index, bus.PRF_req_A_valid, bus.PRF_req_A_PR,
                bus.PRF_req_B_valid, bus.PRF_req_B_PR};
    endfunction

    function automatic logic [95:0] mk_exp(int op, int is_imm, int imm, int aun, int afwd, int abank,
                                           int bfwd, int bbank, int dest, int rob,
                                           int rav, int rapr, int rbv, int rbpr);
        return {22'b0, 4'(op), 1'(is_imm), 32'(imm), 1'(aun), 1'(afwd), 2'(abank), 1'(bfwd),
                2'(bbank), 7'(dest), 7'(rob), 1'(rav), 7'(rapr), 1'(rbv), 7'(rbpr)};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_disp(int op, int is_imm, int imm, int aun, int apr, int ardy,
                            int bpr, int brdy, int dest, int rob);
        bus.dispatch_valid      = 1'b1;
        bus.dispatch_op         = 4'(op);
        bus.dispatch_is_imm     = 1'(is_imm);
        bus.dispatch_imm        = 32'(imm);
        bus.dispatch_A_unneeded = 1'(aun);
        bus.dispatch_A_PR       = 7'(apr);
        bus.dispatch_A_ready    = 1'(ardy);
        bus.dispatch_B_PR       = 7'(bpr);
        bus.dispatch_B_ready    = 1'(brdy);
        bus.dispatch_dest_PR    = 7'(dest);
        bus.dispatch_ROB_index  = 7'(rob);
    endtask

    task automatic disp(int op, int is_imm, int imm, int aun, int apr, int ardy,
                        int bpr, int brdy, int dest, int rob);
        set_disp(op, is_imm, imm, aun, apr, ardy, bpr, brdy, dest, rob);
        tick();
        bus.dispatch_valid = 1'b0;
    endtask

    task automatic wb(int bank, int upper);
        bus.WB_bus_valid_by_bank          = '0;
        bus.WB_bus_valid_by_bank[bank]    = 1'b1;
        bus.WB_bus_upper_PR_by_bank[bank] = 5'(upper);
    endtask

    task automatic wb_clear();
        bus.WB_bus_valid_by_bank    = '0;
        bus.WB_bus_upper_PR_by_bank = '0;
    endtask

    // Scoreboard monitor: each accepted issue must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (!RST && bus.issue_valid && bus.issue_ready) begin
            if (exp_q.size() == 0) check_val("spurious_issue", 96'(bus.issue_valid), 96'd0);
            else                   check_val("issue", iss_word(), exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.dispatch_valid = 1'b0;
        set_disp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.dispatch_valid = 1'b0;
        bus.issue_ready    = 1'b0;
        wb_clear();

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_val("rst_dispatch_ready", 96'(bus.dispatch_ready), 96'd1);
        check_val("rst_issue_valid", 96'(bus.issue_valid), 96'd0);
        w = iss_word();
        check_val("rst_issue_fields", w, 96'd0);
        tick();
        RST = 1'b0;

        // Basic dispatch -> issue one cycle later, both operands read from PRF
        bus.issue_ready = 1'b1;
        set_disp(3, 0, 0, 0, 5, 1, 9, 1, 20, 7);
        exp_q.push_back(mk_exp(3, 0, 0, 0, 0, 0, 0, 0, 20, 7, 1, 5, 1, 9));
        @(negedge CLK);
        check_val("dispatch_cycle_no_issue", 96'(bus.issue_valid), 96'd0);
        tick();
        bus.dispatch_valid = 1'b0;
        @(negedge CLK);
        check_val("lat1_issue_valid", 96'(bus.issue_valid), 96'd1);
        tick();
        @(negedge CLK);
        check_val("empty_after_issue", 96'(bus.issue_valid), 96'd0);
        check_val("basic_drained", 96'(exp_q.size()), 96'd0);
        tick();

        // A waits on PR6 (bank 2, upper 1); writeback forwards in the same cycle
        disp(1, 0, 0, 0, 6, 0, 9, 1, 21, 8);
        @(negedge CLK);
        check_val("wait_on_A", 96'(bus.issue_valid), 96'd0);
        tick();
        wb(2, 1);
        exp_q.push_back(mk_exp(1, 0, 0, 0, 1, 2, 0, 0, 21, 8, 0, 0, 1, 9));
        @(negedge CLK);
        check_val("fwd_A_flag", 96'(bus.issue_A_forward), 96'd1);
        check_val("fwd_A_no_req", 96'(bus.PRF_req_A_valid), 96'd0);
        tick();
        wb_clear();

        // Fill to capacity with the pipeline stalled
        bus.issue_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_disp(i, 1, i * 1000 + 1, 0, 10 + i, 1, 0, 0, 40 + i, i);
            exp_q.push_back(mk_exp(i, 1, i * 1000 + 1, 0, 0, 0, 0, 0, 40 + i, i, 1, 10 + i, 0, 0));
            @(negedge CLK);
            check_val("fill_dispatch_ready", 96'(bus.dispatch_ready), 96'd1);
            tick();
        end
        bus.dispatch_valid = 1'b0;
        @(negedge CLK);
        check_val("full_dispatch_ready", 96'(bus.dispatch_ready), 96'd0);
        check_val("full_head_rob", 96'(bus.issue_ROB_index), 96'd0);
        tick();
        set_disp(9, 0, 0, 0, 30, 1, 31, 1, 99, 99);
        tick();
        bus.dispatch_valid = 1'b0;
        bus.issue_ready = 1'b1;
        @(negedge CLK);
        check_val("full_issuing_ready", 96'(bus.dispatch_ready), 96'd0);
        begin
            int c = 0;
            while (exp_q.size() != 0 && c < 20) begin
                @(posedge CLK);
                c++;
            end
        end
        check_val("fill_drained", 96'(exp_q.size()), 96'd0);
        @(negedge CLK);
        check_val("ninth_dropped", 96'(bus.issue_valid), 96'd0);
        tick();

        // Younger ready op bypasses a waiting head; dispatch during issue lands behind the shift
        bus.issue_ready = 1'b0;
        disp(2, 0, 0, 0, 12, 0, 9, 1, 50, 20);
        disp(4, 0, 0, 0, 13, 1, 14, 1, 51, 21);
        disp(6, 0, 0, 0, 15, 1, 16, 1, 52, 22);
        set_disp(7, 0, 0, 0, 17, 1, 18, 1, 53, 23);
        bus.issue_ready = 1'b1;
        exp_q.push_back(mk_exp(4, 0, 0, 0, 0, 0, 0, 0, 51, 21, 1, 13, 1, 14));
        exp_q.push_back(mk_exp(6, 0, 0, 0, 0, 0, 0, 0, 52, 22, 1, 15, 1, 16));
        exp_q.push_back(mk_exp(7, 0, 0, 0, 0, 0, 0, 0, 53, 23, 1, 17, 1, 18));
        @(negedge CLK);
        tick();
        bus.dispatch_valid = 1'b0;
        @(negedge CLK);
        tick();
        @(negedge CLK);
        tick();
        @(negedge CLK);
        check_val("head_still_waiting", 96'(bus.issue_valid), 96'd0);
        check_val("bypass_drained", 96'(exp_q.size()), 96'd0);
        tick();
        wb(0, 3);
        exp_q.push_back(mk_exp(2, 0, 0, 0, 1, 0, 0, 0, 50, 20, 0, 0, 1, 9));
        @(negedge CLK);
        tick();
        wb_clear();

        // Forward offered while stalled becomes a PRF read on the next cycle
        bus.issue_ready = 1'b0;
        disp(8, 1, 32'hDEAD, 0, 6, 0, 0, 0, 60, 30);
        wb(2, 1);
        @(negedge CLK);
        check_val("hold_issue_valid", 96'(bus.issue_valid), 96'd1);
        check_val("hold_fwd_A", 96'(bus.issue_A_forward), 96'd1);
        check_val("hold_no_req", 96'(bus.PRF_req_A_valid), 96'd0);
        tick();
        wb_clear();
        bus.issue_ready = 1'b1;
        exp_q.push_back(mk_exp(8, 1, 32'hDEAD, 0, 0, 0, 0, 0, 60, 30, 1, 6, 0, 0));
        @(negedge CLK);
        tick();

        // Asynchronous reset with three entries held
        bus.issue_ready = 1'b0;
        disp(0, 0, 0, 0, 33, 1, 34, 1, 70, 40);
        disp(5, 0, 0, 0, 35, 1, 36, 1, 71, 41);
        disp(6, 0, 0, 0, 37, 1, 38, 1, 72, 42);
        @(negedge CLK);
        check_val("held_head_rob", 96'(bus.issue_ROB_index), 96'd40);
        #2;
        RST = 1'b1;
        #1;
        check_val("async_rst_issue_valid", 96'(bus.issue_valid), 96'd0);
        check_val("async_rst_dispatch_ready", 96'(bus.dispatch_ready), 96'd1);
        tick();
        RST = 1'b0;
        bus.issue_ready = 1'b1;
        @(negedge CLK);
        check_val("post_rst_issue_valid", 96'(bus.issue_valid), 96'd0);
        check_val("post_rst_dispatch_ready", 96'(bus.dispatch_ready), 96'd1);
        tick();
        @(negedge CLK);
        check_val("post_rst_still_empty", 96'(bus.issue_valid), 96'd0);
        check_val("final_queue_empty", 96'(exp_q.size()), 96'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_iq.md
# alu_iq

Compressing, oldest-first issue queue for ALU reg-reg/reg-imm ops, between dispatch and alu_pipeline_v2. It holds dispatched ops until their source operands are ready, wakes them up from the PRF writeback bus, and issues at most one op per cycle. Each issue carries PRF read requests or forward selects for its operands.

## Interface
- ALU_IQ_ENTRIES, 8, queue depth (≥2)
- CLK  in  1  clock
- RST  in  1  reset; one clock; asynchronous, active-high
- dispatch_valid  in  1  new op offered
- dispatch_op  in  4  ALU op
- dispatch_is_imm  in  1  B is immediate
- dispatch_imm  in  32  immediate
- dispatch_A_unneeded  in  1  A not read
- dispatch_A_PR, dispatch_B_PR  in  LOG_PR_COUNT  source PRs
- dispatch_A_ready, dispatch_B_ready  in  1  source already written
- dispatch_dest_PR  in  LOG_PR_COUNT  destination PR
- dispatch_ROB_index  in  LOG_ROB_ENTRIES  ROB tag
- dispatch_ready  out  1  queue can accept this cycle
- WB_bus_valid_by_bank  in  PRF_BANK_COUNT  PRF writeback this cycle, per bank
- WB_bus_upper_PR_by_bank  in  PRF_BANK_COUNT×(LOG_PR_COUNT−LOG_PRF_BANK_COUNT)  written PR upper bits
- issue_valid, issue_op, issue_is_imm, issue_imm, issue_A_unneeded, issue_A_forward, issue_A_bank, issue_B_forward, issue_B_bank, issue_dest_PR, issue_ROB_index  out  widths per alu_pipeline_v2 issue port  issued op
- issue_ready  in  1  alu_pipeline_v2 accepts issue
- PRF_req_A_valid, PRF_req_B_valid  out  1  PRF read request
- PRF_req_A_PR, PRF_req_B_PR  out  LOG_PR_COUNT  PR to read

## Operation
- Bank of PR = PR[LOG_PRF_BANK_COUNT−1:0]; WB match for PR p: WB_bus_valid_by_bank[bank(p)] && upper bits equal.
- Entries packed at indices 0..count−1, index 0 oldest. Per entry: valid, op fields, A/B PR, A_ready, B_ready.
- Operand needed: A unless A_unneeded; B unless is_imm. Unneeded operand treated as ready; no request, forward=0.
- Eligible: valid and each needed operand either ready-bit set or WB-matches this cycle.
- Select lowest-index eligible entry; issue_valid=1 with its fields. Per needed operand: ready bit set → PRF_req_X_valid=1, PR driven, forward=0. Ready bit clear but WB match → forward=1, bank=bank(PR), no request.
- PRF requests asserted only with issue_valid && issue_ready; else 0.
- issue_valid && issue_ready: selected entry removed; entries above shift down one.
- issue_valid && !issue_ready: no state change except wakeups; selection re-evaluated next cycle (forward becomes ready-bit read).
- Wakeup: every valid entry sets ready bit on WB match every cycle, including the entry being held.
- dispatch_ready = (count < ALU_IQ_ENTRIES). Accept on dispatch_valid && dispatch_ready; write at index count, or count−1 if an issue occurs the same cycle. Ready bits = dispatch_X_ready OR WB match this cycle. A newly dispatched op is never eligible in its dispatch cycle.
- count next = count + accept − issue.

## Timing
- Reset (async, RST=1): all entries invalid, count=0; outputs: issue_valid=0, all issue fields 0, PRF_req_* 0, dispatch_ready=1.
- issue_* and PRF_req_* combinational from state + same-cycle WB bus + issue_ready; alu_pipeline_v2 samples next edge.
- Min dispatch→issue latency 1 cycle; WB→dependent issue 0 cycles (forward).
- Full (count=N): dispatch_ready=0 even if issuing this cycle.
- Empty: issue_valid=0.
- RST mid-operation discards all entries immediately.

## Structure
- core_types_pkg: PRF_BANK_COUNT, LOG_PRF_BANK_COUNT, LOG_PR_COUNT, LOG_ROB_ENTRIES, ALU op encoding; add alu_iq_entry_t packed struct.
- One sub-module: alu_iq_pe_lsb, a parameterized lowest-set-bit priority encoder (one-hot + index) for selection.

## Test plan
- Reset with RST pulse mid-run (3 entries held) → count 0, issue_valid=0, dispatch_ready=1 next cycle.
- Dispatch op3, A=PR5 ready, B=PR9 ready, dest=PR20, ROB 7; issue_ready=1 → next cycle issue_valid, PRF_req_A_PR=5, PRF_req_B_PR=9, both forwards 0, queue empty after.
- Dispatch A=PR6 not ready; two cycles later WB bank 2 upper=1 (PR6) → same cycle issue_A_forward=1, issue_A_bank=2, PRF_req_A_valid=0.
- Fill 8 entries with issue_ready=0 → dispatch_ready=0 at count 8; ninth dispatch dropped; release → entries issue in order of ROB 0..7.
- Entry0 waiting, entry1 ready → entry1 issues first; entry2 shifts to index1; simultaneous dispatch lands at index 2.
- Forward offered with issue_ready=0 → next cycle same op issues with forward=0, PRF_req valid for that PR.
